// File: rtl/regs_wb_port.sv
// regs_wb_port: architectural integer register file (x0 hardwired to zero).
// Terminates the EX/WB writeback port and serves two combinational read
// ports plus a request/acknowledge debug access port.
// Optional feature macro: REGS_BYPASS_EN enables a same-cycle write-to-read
// bypass on both read ports.
module regs_wb_port #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_ack_o,
    output logic [DATA_W-1:0] dbg_rdata_o
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t state;

    // x1..x(NREGS-1); x0 has no storage
    logic [DATA_W-1:0] regs [1:NREGS-1];

    logic core_wr;
    logic dbg_accept;
    logic dbg_wr;
    logic dbg_rd;
    logic [DATA_W-1:0] store1;
    logic [DATA_W-1:0] store2;
    logic [DATA_W-1:0] store_dbg;

    // Storage lookup: index 0 and any index without storage read as zero
    function automatic logic [DATA_W-1:0] stored(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if ((a != '0) && (int'(a) < int'(NREGS))) begin
            v = regs[a];
        end
        return v;
    endfunction

    // Writable-index test shared by the core and debug write paths
    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return (a != '0) && (int'(a) < int'(NREGS));
    endfunction

    // Arbitration: a debug write yields to any effective core write
    always_comb begin
        core_wr    = we_i && writable(waddr_i);
        dbg_accept = dbg_req_i && (state == IDLE) && !dbg_ack_o
                     && !(dbg_we_i && we_i && (waddr_i != '0));
        dbg_wr     = dbg_accept && dbg_we_i && writable(dbg_addr_i);
        dbg_rd     = dbg_accept && !dbg_we_i;
    end

    // Pre-edge storage values for all readers
    always_comb begin
        store1    = stored(raddr1_i);
        store2    = stored(raddr2_i);
        store_dbg = stored(dbg_addr_i);
    end

`ifdef REGS_BYPASS_EN
    // Read ports with same-cycle writeback bypass (core writes only)
    always_comb begin
        rdata1_o = store1;
        rdata2_o = store2;
        if (we_i && (waddr_i == raddr1_i) && (raddr1_i != '0)) begin
            rdata1_o = wdata_i;
        end
        if (we_i && (waddr_i == raddr2_i) && (raddr2_i != '0)) begin
            rdata2_o = wdata_i;
        end
    end
`else
    // Read ports straight from storage; same-cycle writes are not visible
    always_comb begin
        rdata1_o = store1;
        rdata2_o = store2;
    end
`endif

    // Register storage: reset clears, core write and accepted debug write
    // are mutually exclusive by arbitration
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (core_wr) begin
                regs[waddr_i] <= wdata_i;
            end
            if (dbg_wr) begin
                regs[dbg_addr_i] <= dbg_wdata_i;
            end
        end
    end

    // Debug handshake FSM with registered ack and read data
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            dbg_ack_o   <= 1'b0;
            dbg_rdata_o <= '0;
        end else begin
            dbg_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (dbg_accept) begin
                        state     <= ACK;
                        dbg_ack_o <= 1'b1;
                        if (dbg_rd) begin
                            dbg_rdata_o <= store_dbg;
                        end
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regs_wb_port.sv
// Directed self-checking bench for regs_wb_port.
module tb_regs_wb_port;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREGS  = 32;

    logic              clk;
    logic              rst;
    logic              we_i;
    logic [ADDR_W-1:0] waddr_i;
    logic [DATA_W-1:0] wdata_i;
    logic [ADDR_W-1:0] raddr1_i;
    logic [DATA_W-1:0] rdata1_o;
    logic [ADDR_W-1:0] raddr2_i;
    logic [DATA_W-1:0] rdata2_o;
    logic              dbg_req_i;
    logic              dbg_we_i;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [DATA_W-1:0] dbg_wdata_i;
    logic              dbg_ack_o;
    logic [DATA_W-1:0] dbg_rdata_o;

    int passed;
    int total;

    regs_wb_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
        .clk(clk), .rst(rst),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr1_i(raddr1_i), .rdata1_o(rdata1_o),
        .raddr2_i(raddr2_i), .rdata2_o(rdata2_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus: one core write, then release the port
    task automatic core_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        tick();
        we_i = 1'b0;
    endtask

    task automatic test_reset();
        core_write(5'd2, 32'h77);
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd2;
        tick();
        dbg_req_i = 1'b0;
        total++;
        if (dbg_rdata_o !== 32'h77) $display("FAIL pre_reset_dbg_rdata got %h want %h", dbg_rdata_o, 32'h77);
        else passed++;
        core_write(5'd17, 32'h1717);
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            raddr1_i = ADDR_W'(i);
            #1;
            total++;
            if (rdata1_o !== 32'h0) $display("FAIL reset_reg%0d got %h want 0", i, rdata1_o);
            else passed++;
        end
        total++;
        if (dbg_ack_o !== 1'b0) $display("FAIL reset_ack got %b want 0", dbg_ack_o);
        else passed++;
        total++;
        if (dbg_rdata_o !== 32'h0) $display("FAIL reset_dbg_rdata got %h want 0", dbg_rdata_o);
        else passed++;
    endtask

    task automatic test_write_read();
        core_write(5'd5, 32'hDEADBEEF);
        raddr1_i = 5'd5; raddr2_i = 5'd5;
        #1;
        total++;
        if (rdata1_o !== 32'hDEADBEEF) $display("FAIL wr_rd_port1 got %h want %h", rdata1_o, 32'hDEADBEEF);
        else passed++;
        total++;
        if (rdata2_o !== 32'hDEADBEEF) $display("FAIL wr_rd_port2 got %h want %h", rdata2_o, 32'hDEADBEEF);
        else passed++;
        core_write(5'd0, 32'h12345678);
        raddr2_i = 5'd0;
        #1;
        total++;
        if (rdata2_o !== 32'h0) $display("FAIL x0_write got %h want 0", rdata2_o);
        else passed++;
        core_write(5'd31, 32'h3131_0000);
        raddr1_i = 5'd31;
        #1;
        total++;
        if (rdata1_o !== 32'h3131_0000) $display("FAIL reg31 got %h want %h", rdata1_o, 32'h3131_0000);
        else passed++;
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] exp;
        core_write(5'd7, 32'h11);
        we_i = 1'b1; waddr_i = 5'd7; wdata_i = 32'hA5A5A5A5;
        raddr1_i = 5'd7; raddr2_i = 5'd0;
        #1;
`ifdef REGS_BYPASS_EN
        exp = 32'hA5A5A5A5;
`else
        exp = 32'h11;
`endif
        total++;
        if (rdata1_o !== exp) $display("FAIL bypass_same_cycle got %h want %h", rdata1_o, exp);
        else passed++;
        waddr_i = 5'd0;
        #1;
        total++;
        if (rdata2_o !== 32'h0) $display("FAIL bypass_x0 got %h want 0", rdata2_o);
        else passed++;
        waddr_i = 5'd7;
        tick();
        we_i = 1'b0;
        #1;
        total++;
        if (rdata1_o !== 32'hA5A5A5A5) $display("FAIL bypass_next_cycle got %h want %h", rdata1_o, 32'hA5A5A5A5);
        else passed++;
    endtask

    task automatic test_debug_read();
        core_write(5'd9, 32'hCAFE0001);
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd9;
        #1;
        total++;
        if (dbg_ack_o !== 1'b0) $display("FAIL dbg_rd_early_ack got %b want 0", dbg_ack_o);
        else passed++;
        // same-edge core write to reg9 must not be seen by the debug read
        we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'h0BAD0BAD;
        tick();
        we_i = 1'b0;
        dbg_req_i = 1'b0;
        total++;
        if (dbg_ack_o !== 1'b1) $display("FAIL dbg_rd_ack got %b want 1", dbg_ack_o);
        else passed++;
        total++;
        if (dbg_rdata_o !== 32'hCAFE0001) $display("FAIL dbg_rd_data got %h want %h", dbg_rdata_o, 32'hCAFE0001);
        else passed++;
        tick();
        total++;
        if (dbg_ack_o !== 1'b0) $display("FAIL dbg_rd_single_pulse got %b want 0", dbg_ack_o);
        else passed++;
        total++;
        if (dbg_rdata_o !== 32'hCAFE0001) $display("FAIL dbg_rd_hold got %h want %h", dbg_rdata_o, 32'hCAFE0001);
        else passed++;
        tick();
        total++;
        if (dbg_ack_o !== 1'b0) $display("FAIL dbg_no_unrequested got %b want 0", dbg_ack_o);
        else passed++;
    endtask

    task automatic test_debug_conflict();
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd3; dbg_wdata_i = 32'h55;
        we_i = 1'b1; waddr_i = 5'd4; wdata_i = 32'h99;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (dbg_ack_o !== 1'b0) $display("FAIL conflict_ack_cyc%0d got %b want 0", c, dbg_ack_o);
            else passed++;
        end
        we_i = 1'b0;
        raddr1_i = 5'd3;
        #1;
        total++;
        if (rdata1_o !== 32'h0) $display("FAIL conflict_deferred got %h want 0", rdata1_o);
        else passed++;
        tick();
        dbg_req_i = 1'b0;
        total++;
        if (dbg_ack_o !== 1'b1) $display("FAIL conflict_ack got %b want 1", dbg_ack_o);
        else passed++;
        raddr2_i = 5'd4;
        #1;
        total++;
        if (rdata1_o !== 32'h55) $display("FAIL conflict_reg3 got %h want %h", rdata1_o, 32'h55);
        else passed++;
        total++;
        if (rdata2_o !== 32'h99) $display("FAIL conflict_reg4 got %h want %h", rdata2_o, 32'h99);
        else passed++;
        tick();
        // core write to x0 is not effective and must not defer a debug write
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd8; dbg_wdata_i = 32'h88;
        we_i = 1'b1; waddr_i = 5'd0; wdata_i = 32'hFFFF;
        raddr1_i = 5'd8;
        #1;
        total++;
        if (rdata1_o !== 32'h0) $display("FAIL dbg_wr_no_bypass got %h want 0", rdata1_o);
        else passed++;
        tick();
        we_i = 1'b0;
        dbg_req_i = 1'b0;
        total++;
        if (dbg_ack_o !== 1'b1) $display("FAIL x0_no_conflict_ack got %b want 1", dbg_ack_o);
        else passed++;
        total++;
        if (rdata1_o !== 32'h88) $display("FAIL dbg_wr_visible got %h want %h", rdata1_o, 32'h88);
        else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_ack [4];
        exp_ack[0] = 1'b1; exp_ack[1] = 1'b0; exp_ack[2] = 1'b1; exp_ack[3] = 1'b0;
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c == 2) dbg_req_i = 1'b0;
            total++;
            if (dbg_ack_o !== exp_ack[c]) $display("FAIL b2b_ack_cyc%0d got %b want %b", c, dbg_ack_o, exp_ack[c]);
            else passed++;
        end
        total++;
        if (dbg_rdata_o !== 32'h0) $display("FAIL dbg_rd_x0 got %h want 0", dbg_rdata_o);
        else passed++;
    endtask

    task automatic test_reset_mid_access();
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd10; dbg_wdata_i = 32'hABCD;
        tick();
        dbg_req_i = 1'b0;
        total++;
        if (dbg_ack_o !== 1'b1) $display("FAIL mid_rst_accept got %b want 1", dbg_ack_o);
        else passed++;
        rst = 1'b0;
        we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'h1111;
        tick();
        rst = 1'b1;
        we_i = 1'b0;
        raddr1_i = 5'd10; raddr2_i = 5'd11;
        #1;
        total++;
        if (dbg_ack_o !== 1'b0) $display("FAIL mid_rst_ack got %b want 0", dbg_ack_o);
        else passed++;
        total++;
        if (rdata1_o !== 32'h0) $display("FAIL mid_rst_reg10 got %h want 0", rdata1_o);
        else passed++;
        total++;
        if (rdata2_o !== 32'h0) $display("FAIL mid_rst_reg11 got %h want 0", rdata2_o);
        else passed++;
        tick();
        total++;
        if (dbg_ack_o !== 1'b0) $display("FAIL post_rst_ack got %b want 0", dbg_ack_o);
        else passed++;
    endtask

    initial begin
        passed = 0; total = 0;
        rst = 1'b0; we_i = 1'b0; waddr_i = '0; wdata_i = '0;
        raddr1_i = '0; raddr2_i = '0;
        dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
        tick(); tick();
        rst = 1'b1;
        test_reset();
        test_write_read();
        test_bypass();
        test_debug_read();
        test_debug_conflict();
        test_back_to_back();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
